// File: rtl/mavg_filter.sv
// rtl/mavg_filter.sv - streaming moving-average filter over the last 2^LOG2_N accepted samples
module mavg_filter #(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 2,
    parameter int ROUND  = 0
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] x,
    output logic              out_valid,
    output logic [DATA_W-1:0] y,
    output logic              primed
);

    localparam int N     = 1 << LOG2_N;
    localparam int SUM_W = DATA_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [SUM_W-1:0] RND = (ROUND != 0) ? SUM_W'(N / 2) : '0;

    logic [DATA_W-1:0] samples_q [N];
    logic [DATA_W-1:0] samples_d [N];
    logic [LOG2_N-1:0] ptr_q, ptr_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic              out_valid_q, out_valid_d;
    logic              primed_q, primed_d;

    logic [SUM_W-1:0]  oldest;
    logic [SUM_W-1:0]  sum_next;
    logic [SUM_W-1:0]  sum_rnd;

    always_comb begin
        samples_d   = samples_q;
        ptr_d       = ptr_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        y_d         = y_q;
        primed_d    = primed_q;
        out_valid_d = in_valid;

        // Slots not yet written since reset contribute zero to the window.
        oldest   = primed_q ? SUM_W'(samples_q[ptr_q]) : '0;
        sum_next = sum_q + SUM_W'(x) - oldest;
        sum_rnd  = sum_next + RND;

        if (in_valid) begin
            samples_d[ptr_q] = x;
            ptr_d            = ptr_q + LOG2_N'(1);
            sum_d            = sum_next;
            y_d              = sum_rnd[SUM_W-1:LOG2_N];
            if (fill_q != CNT_W'(N)) begin
                fill_d = fill_q + CNT_W'(1);
            end
            primed_d = primed_q | (fill_d == CNT_W'(N));
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            samples_q   <= '{default: '0};
            ptr_q       <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            samples_q   <= samples_d;
            ptr_q       <= ptr_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            primed_q    <= primed_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign primed    = primed_q;

endmodule
